// File: rtl/rv_dmem_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_dmem_if
// Description : Memory-stage request/response bundle between the RV core
//               control path (master) and the data-memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_dmem_if #(
    parameter int ADDR_W = 32
);
    logic              mem_read_i;
    logic              mem_write_i;
    logic [2:0]        funct3_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              ready_o;
    logic              err_o;
    logic              stall_o;

    modport master (
        output mem_read_i, mem_write_i, funct3_i, addr_i, wdata_i,
        input  rdata_o, ready_o, err_o, stall_o
    );

    modport slave (
        input  mem_read_i, mem_write_i, funct3_i, addr_i, wdata_i,
        output rdata_o, ready_o, err_o, stall_o
    );
endinterface
`default_nettype wire

// File: rtl/rv_dmem.sv
`default_nettype none
// ============================================================================
// Module      : rv_dmem
// Description : Data-memory responder: byte/half/word loads and stores on a
//               word-wide array after WAIT wait states, with error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_dmem #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int WAIT   = 2
) (
    input wire       clk,
    input wire       rst,
    rv_dmem_if.slave bus
);
    localparam int         c_idx_w   = $clog2(DEPTH);
    localparam int         c_la_w    = c_idx_w + 2;
    localparam logic [3:0] c_wait_m1 = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_rd;
    logic               r_wr;
    logic [2:0]         r_f3;
    logic [c_la_w-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_ready;
    logic               r_err;

    logic [31:0]        r_mem [DEPTH];

    logic               w_req;
    logic               w_fire;
    logic               w_rd;
    logic               w_wr;
    logic [2:0]         w_f3;
    logic [c_la_w-1:0]  w_addr;
    logic [31:0]        w_wdata;
    logic [c_idx_w-1:0] w_idx;
    logic               w_size_err;
    logic               w_f3_err;
    logic               w_err;
    logic [31:0]        w_word;
    logic [31:0]        w_shift;
    logic [31:0]        w_ldata;
    logic [3:0]         w_be;
    logic [31:0]        w_wd;
    logic               w_we;

    assign w_req = bus.mem_read_i | bus.mem_write_i;

    // Access completes on the edge entering RESP; with no wait states that is
    // the accept edge itself, so the request is taken straight from the bus.
    assign w_fire = ((r_state == S_IDLE) && w_req && (WAIT == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd0));

    always_comb begin
        w_rd    = r_rd;
        w_wr    = r_wr;
        w_f3    = r_f3;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        if (r_state == S_IDLE) begin
            w_rd    = bus.mem_read_i;
            w_wr    = bus.mem_write_i;
            w_f3    = bus.funct3_i;
            w_addr  = bus.addr_i[c_la_w-1:0];
            w_wdata = bus.wdata_i;
        end
    end

    assign w_idx = w_addr[c_la_w-1:2];

    always_comb begin
        w_size_err = 1'b0;
        case (w_f3[1:0])
            2'b01:   w_size_err = w_addr[0];
            2'b10:   w_size_err = (w_addr[1:0] != 2'b00);
            default: w_size_err = 1'b0;
        endcase
        // Loads allow 000/001/010/100/101; stores allow 000/001/010 only.
        if (w_wr) begin
            w_f3_err = w_f3[2] | (w_f3[1:0] == 2'b11);
        end else begin
            w_f3_err = (w_f3[1:0] == 2'b11) | (w_f3 == 3'b110);
        end
        w_err = (w_rd & w_wr) | w_f3_err | w_size_err;
    end

    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_addr[1:0], 3'b000};

    always_comb begin
        case (w_f3)
            3'b000:  w_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ldata = {24'd0, w_shift[7:0]};
            3'b101:  w_ldata = {16'd0, w_shift[15:0]};
            default: w_ldata = w_word;
        endcase
    end

    always_comb begin
        w_be = 4'b1111;
        w_wd = w_wdata;
        case (w_f3[1:0])
            2'b00: begin
                w_be = 4'b0001 << w_addr[1:0];
                w_wd = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be = 4'b1111;
                w_wd = w_wdata;
            end
        endcase
    end

    // A reset on the completing edge must keep the store out of the array.
    assign w_we = w_fire & w_wr & ~w_err & ~rst;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_rd    <= bus.mem_read_i;
                        r_wr    <= bus.mem_write_i;
                        r_f3    <= bus.funct3_i;
                        r_addr  <= bus.addr_i[c_la_w-1:0];
                        r_wdata <= bus.wdata_i;
                        if (WAIT == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_wait_m1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_fire) begin
                r_ready <= 1'b1;
                r_err   <= w_err;
                // Error responses return zero; successful stores leave the
                // previous load data in place.
                if (w_err) begin
                    r_rdata <= 32'd0;
                end else if (w_rd) begin
                    r_rdata <= w_ldata;
                end
            end
        end
    end

    assign bus.rdata_o = r_rdata;
    assign bus.ready_o = r_ready;
    assign bus.err_o   = r_err;
    assign bus.stall_o = w_req & ~r_ready;
endmodule
`default_nettype wire

// File: tb/tb_rv_dmem.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_dmem
// Description : Self-checking bench for rv_dmem: one instance with WAIT=2 and
//               one with WAIT=0, directed vector table plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_dmem;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;

    always #5 clk = ~clk;

    rv_dmem_if #(.ADDR_W(32)) bus_a ();
    rv_dmem_if #(.ADDR_W(32)) bus_b ();

    assign bus_a.mem_read_i  = rd & ~sel;
    assign bus_a.mem_write_i = wr & ~sel;
    assign bus_a.funct3_i    = f3;
    assign bus_a.addr_i      = addr;
    assign bus_a.wdata_i     = wd;
    assign bus_b.mem_read_i  = rd & sel;
    assign bus_b.mem_write_i = wr & sel;
    assign bus_b.funct3_i    = f3;
    assign bus_b.addr_i      = addr;
    assign bus_b.wdata_i     = wd;

    rv_dmem #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    rv_dmem #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_err;
    logic        o_stall;
    assign o_rdata = sel ? bus_b.rdata_o : bus_a.rdata_o;
    assign o_ready = sel ? bus_b.ready_o : bus_a.ready_o;
    assign o_err   = sel ? bus_b.err_o   : bus_a.err_o;
    assign o_stall = sel ? bus_b.stall_o : bus_a.stall_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: byte-addressed image of each instance, last load data held.
    logic [7:0]  mb   [2][4096];
    logic [31:0] hold [2];

    typedef struct {
        logic        s;
        logic        r;
        logic        w;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] q;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic access(input logic s, input logic r, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] q, output logic e, output int lat,
                          output int nst, output logic st_rdy, output int nbad);
        q = 32'd0; e = 1'b0; lat = 0; nst = 0; st_rdy = 1'b0; nbad = 0;
        @(posedge clk); #1;
        sel = s; rd = r; wr = w; f3 = f; addr = a; wd = d;
        #1;
        if (o_stall) nst++;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (o_ready) begin
                lat = c; q = o_rdata; e = o_err; st_rdy = o_stall;
                break;
            end
            if (o_stall) nst++;
            if (o_err) nbad++;
            f3 = 3'($urandom); addr = $urandom; wd = $urandom;
        end
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic s, input logic r, input logic w,
                          input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                          input logic ee, input logic [31:0] eq);
        logic [31:0] q;
        logic        e;
        logic        sr;
        int          lat;
        int          nst;
        int          nbad;
        access(s, r, w, f, a, d, q, e, lat, nst, sr, nbad);
        chk({nm, " err"}, 32'(e), 32'(ee));
        chk({nm, " rdata"}, q, eq);
        chk({nm, " latency"}, 32'(lat), s ? 32'd1 : 32'd3);
        chk({nm, " stall cycles"}, 32'(nst), s ? 32'd1 : 32'd3);
        chk({nm, " stall at ready"}, 32'(sr), 32'd0);
        chk({nm, " err without ready"}, 32'(nbad), 32'd0);
    endtask

    task automatic model(input int s, input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic e, output logic [31:0] q);
        int          off;
        int          n;
        bit          legal;
        logic [31:0] v;
        off = int'(a[11:0]);
        n   = 1 << f[1:0];
        if (r) legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
        else   legal = (f <= 3'd2);
        e = (r && w) || !legal || ((off % n) != 0);
        if (e) begin
            hold[s] = 32'd0;
        end else if (w) begin
            for (int i = 0; i < n; i++) mb[s][off+i] = d[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(mb[s][off+i]) << (8*i));
            if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            hold[s] = v;
        end
        q = hold[s];
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        hold[0] = 32'd0;
        hold[1] = 32'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] q;
        logic [31:0] a;
        logic        s;
        logic        r;
        logic        w;
        int          k;

        rst = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; f3 = 3'd0; addr = 32'd0; wd = 32'd0;
        hold[0] = 32'd0; hold[1] = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready_a", 32'(bus_a.ready_o), 32'd0);
        chk("reset err_a",   32'(bus_a.err_o),   32'd0);
        chk("reset rdata_a", bus_a.rdata_o,      32'd0);
        chk("reset ready_b", 32'(bus_b.ready_o), 32'd0);
        chk("reset rdata_b", bus_b.rdata_o,      32'd0);
        rst = 1'b0;

        // Requests while reset is held produce nothing and leave the array alone
        run_op("sw 0x40", 1'b0, 1'b0, 1'b1, 3'b010, 32'h40, 32'h1111_2222, 1'b0, hold[0]);
        @(posedge clk); #1;
        rst = 1'b1; sel = 1'b0; wr = 1'b1; rd = 1'b0; f3 = 3'b010; addr = 32'h40; wd = 32'hFFFF_FFFF;
        k = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (o_ready) k++;
            rd = ~rd;
        end
        chk("ready under reset", 32'(k), 32'd0);
        rst = 1'b0; rd = 1'b0; wr = 1'b0;
        hold[0] = 32'd0; hold[1] = 32'd0;
        hold[0] = 32'h1111_2222;
        run_op("lw 0x40 after reset pulse", 1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 1'b0, hold[0]);

        // Directed vectors: {sel, rd, wr, funct3, addr, wdata, err, rdata}
        tbl.push_back('{1'b0, 1'b0, 1'b1, 3'b010, 32'h10,   32'h8765_43A1, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'b010, 32'h10,   32'd0,         1'b0, 32'h8765_43A1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'b000, 32'h10,   32'd0,         1'b0, 32'hFFFF_FFA1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'b100, 32'h10,   32'd0,         1'b0, 32'h0000_00A1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'b001, 32'h12,   32'd0,         1'b0, 32'hFFFF_8765});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'b101, 32'h12,   32'd0,         1'b0, 32'h0000_8765});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 3'b000, 32'h11,   32'h0000_0055, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'b010, 32'h10,   32'd0,         1'b0, 32'h8765_55A1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'b010, 32'h12,   32'd0,         1'b1, 32'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 3'b001, 32'h13,   32'h0000_BEEF, 1'b1, 32'd0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'b010, 32'h10,   32'd0,         1'b0, 32'h8765_55A1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'b011, 32'h10,   32'd0,         1'b1, 32'd0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 3'b010, 32'h10,   32'd0,         1'b1, 32'd0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'b010, 32'h10,   32'd0,         1'b0, 32'h8765_55A1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 3'b001, 32'h12,   32'hAAAA_1234, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'b010, 32'h10,   32'd0,         1'b0, 32'h1234_55A1});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 3'b010, 32'(DEPTH*4 + 4), 32'h1234_5678, 1'b0, 32'd0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b010, 32'h4,    32'd0,         1'b0, 32'h1234_5678});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b110, 32'h4,    32'd0,         1'b1, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 3'b011, 32'h4,    32'hFFFF_FFFF, 1'b1, 32'd0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b010, 32'h4,    32'd0,         1'b0, 32'h1234_5678});

        foreach (tbl[i]) begin
            if (tbl[i].r || tbl[i].e) hold[tbl[i].s] = tbl[i].q;
            run_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].r, tbl[i].w, tbl[i].f,
                   tbl[i].a, tbl[i].d, tbl[i].e, hold[tbl[i].s]);
        end

        // Reset while a store is waiting: the store must be dropped
        hold[0] = hold[0];
        run_op("sw 0x20 pre", 1'b0, 1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 1'b0, hold[0]);
        @(posedge clk); #1;
        sel = 1'b0; wr = 1'b1; rd = 1'b0; f3 = 3'b010; addr = 32'h20; wd = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b1; wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        hold[0] = 32'd0; hold[1] = 32'd0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_ready) k++;
            @(posedge clk); #1;
        end
        chk("ready after mid-op reset", 32'(k), 32'd0);
        chk("rdata after mid-op reset", o_rdata, 32'd0);
        hold[0] = 32'hCAFE_F00D;
        run_op("lw 0x20 after dropped store", 1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 1'b0, hold[0]);

        // Random traffic against the byte-level model on words 0x100..0x13F
        pulse_reset();
        for (int si = 0; si < 2; si++) begin
            for (int wi = 0; wi < 16; wi++) begin
                a = 32'h100 | 32'(wi << 2);
                model(si, 1'b0, 1'b1, 3'b010, a, $urandom, e, q);
                run_op("preload", 1'(si), 1'b0, 1'b1, 3'b010, a, {mb[si][a[11:0]+3], mb[si][a[11:0]+2],
                       mb[si][a[11:0]+1], mb[si][a[11:0]]}, e, q);
            end
        end
        for (int it = 0; it < 150; it++) begin
            logic [31:0] d;
            logic [2:0]  f;
            s = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 9);
            r = (k < 5);
            w = (k == 0) || (k >= 5);
            f = 3'($urandom_range(0, 7));
            d = $urandom;
            a = ($urandom & 32'hFFFF_F000) | 32'h100 | 32'($urandom_range(0, 15) << 2) |
                32'($urandom_range(0, 3));
            model(int'(s), r, w, f, a, d, e, q);
            run_op($sformatf("rand%0d", it), s, r, w, f, a, d, e, q);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
